// File: rtl/mux_pipe_stage.sv
// Selects one of NUM_IN inputs and buffers it in a two-entry skid FIFO.
// in_ready depends only on registered state, so out_ready has no combinational path to it.
module mux_pipe_stage #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 3,
    parameter int               SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state_r;
    logic [WIDTH-1:0] head_data_r;
    logic             head_err_r;
    logic [WIDTH-1:0] skid_data_r;
    logic             skid_err_r;

    logic [NUM_IN-1:0] sel_hit_s;
    logic [WIDTH-1:0]  sel_or_s;
    logic [WIDTH-1:0]  sel_data_s;
    logic              sel_err_s;
    logic              push_s;
    logic              pop_s;

    // One-hot AND-OR input mux; no hit means the select was out of range
    always_comb begin
        sel_hit_s = '0;
        sel_or_s  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            sel_hit_s[i] = (in_sel == SEL_W'(i));
            sel_or_s     = sel_or_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{sel_hit_s[i]}});
        end
        sel_err_s  = ~(|sel_hit_s);
        sel_data_s = sel_err_s ? DEFAULT_VAL : sel_or_s;
    end

    // Held low during reset so upstream cannot push into a stage being cleared
    assign in_ready    = ~rst & (state_r != ST_FULL);
    assign out_valid   = (state_r != ST_EMPTY);
    assign out_data    = head_data_r;
    assign out_sel_err = head_err_r;

    assign push_s = in_valid & in_ready & ~flush;
    assign pop_s  = out_valid & out_ready & ~flush;

    // Skid buffer state, head and skid registers; head is zeroed whenever empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            head_data_r <= '0;
            head_err_r  <= 1'b0;
            skid_data_r <= '0;
            skid_err_r  <= 1'b0;
        end else if (flush) begin
            state_r     <= ST_EMPTY;
            head_data_r <= '0;
            head_err_r  <= 1'b0;
            skid_data_r <= '0;
            skid_err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_r     <= ST_ONE;
                        head_data_r <= sel_data_s;
                        head_err_r  <= sel_err_s;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        head_data_r <= sel_data_s;
                        head_err_r  <= sel_err_s;
                    end else if (push_s) begin
                        state_r     <= ST_FULL;
                        skid_data_r <= sel_data_s;
                        skid_err_r  <= sel_err_s;
                    end else if (pop_s) begin
                        state_r     <= ST_EMPTY;
                        head_data_r <= '0;
                        head_err_r  <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so a pop only promotes the skid entry
                    if (pop_s) begin
                        state_r     <= ST_ONE;
                        head_data_r <= skid_data_r;
                        head_err_r  <= skid_err_r;
                        skid_data_r <= '0;
                        skid_err_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    head_data_r <= '0;
                    head_err_r  <= 1'b0;
                    skid_data_r <= '0;
                    skid_err_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Self-checking bench for mux_pipe_stage: directed scenarios plus a random run,
// all checked against a queue-based reference FIFO.
module tb_mux_pipe_stage;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic                    out_sel_err;
    logic                    out_valid;
    logic                    out_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [WIDTH:0] sb_q[$];

    mux_pipe_stage #(
        .WIDTH      (WIDTH),
        .NUM_IN     (NUM_IN),
        .SEL_W      (SEL_W),
        .DEFAULT_VAL(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_data   (out_data),
        .out_sel_err(out_sel_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] expect_entry(input logic [SEL_W-1:0] s);
        case (s)
            2'd0:    return {1'b0, 32'hAAAA_AAAA};
            2'd1:    return {1'b0, 32'hBBBB_BBBB};
            2'd2:    return {1'b0, 32'hCCCC_CCCC};
            default: return {1'b1, 32'h0000_0000};
        endcase
    endfunction

    function automatic logic [WIDTH+1:0] exp_head();
        if (sb_q.size() == 0) return '0;
        return {1'b1, sb_q[0]};
    endfunction

    // Advance one clock, updating the reference FIFO with the handshakes of that edge
    task automatic step();
        logic push;
        logic pop;
        push = in_valid && (sb_q.size() < 2) && !flush && !rst;
        pop  = (sb_q.size() > 0) && out_ready && !flush && !rst;
        @(posedge clk);
        if (rst || flush) begin
            sb_q.delete();
        end else begin
            if (pop) void'(sb_q.pop_front());
            if (push) sb_q.push_back(expect_entry(in_sel));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; flush = 1'b0; out_ready = 1'b0;
        in_data = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        #2;
        tests_run++;
        if ({out_valid, out_sel_err, out_data, in_ready} !== 35'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", {out_valid, out_sel_err, out_data, in_ready});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_sweep();
        logic [WIDTH+1:0] exp_tab [4];
        exp_tab[0] = {2'b10, 32'hAAAA_AAAA};
        exp_tab[1] = {2'b10, 32'hBBBB_BBBB};
        exp_tab[2] = {2'b10, 32'hCCCC_CCCC};
        exp_tab[3] = {2'b11, 32'h0000_0000};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sel = SEL_W'(i);
            step();
            tests_run++;
            if ({out_valid, out_sel_err, out_data} !== exp_tab[i] || in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL sweep_sel%0d: got %h/%b expected %h/1", i, {out_valid, out_sel_err, out_data}, in_ready, exp_tab[i]);
            end
        end
        in_valid = 1'b0;
        step();
        tests_run++;
        if ({out_valid, out_sel_err, out_data} !== 34'd0) begin
            tests_failed++;
            $display("FAIL sweep_drain: got %h expected 0", {out_valid, out_sel_err, out_data});
        end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        step();
        in_sel = 2'd1;
        step();
        in_valid = 1'b0;
        step();
        tests_run++;
        if (in_ready !== 1'b0 || {out_valid, out_sel_err, out_data} !== {2'b10, 32'hAAAA_AAAA}) begin
            tests_failed++;
            $display("FAIL full_hold: got %b/%h expected 0/%h", in_ready, {out_valid, out_sel_err, out_data}, {2'b10, 32'hAAAA_AAAA});
        end
        // Pop while FULL with an offer pending: offer must not be taken
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        out_ready = 1'b1;
        step();
        tests_run++;
        if (in_ready !== 1'b1 || {out_valid, out_sel_err, out_data} !== {2'b10, 32'hBBBB_BBBB} || sb_q.size() != 1) begin
            tests_failed++;
            $display("FAIL full_pop_no_push: got %b/%h expected 1/%h", in_ready, {out_valid, out_sel_err, out_data}, {2'b10, 32'hBBBB_BBBB});
        end
        in_valid = 1'b0;
        step();
        tests_run++;
        if ({out_valid, out_sel_err, out_data} !== 34'd0) begin
            tests_failed++;
            $display("FAIL full_drain: got %h expected 0", {out_valid, out_sel_err, out_data});
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        step();
        flush  = 1'b1;
        in_sel = 2'd2;
        step();
        tests_run++;
        if ({out_valid, out_sel_err, out_data} !== 34'd0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_empty: got %h/%b expected 0/1", {out_valid, out_sel_err, out_data}, in_ready);
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        tests_run++;
        if ({out_valid, out_sel_err, out_data} !== 34'd0) begin
            tests_failed++;
            $display("FAIL flush_dropped: got %h expected 0", {out_valid, out_sel_err, out_data});
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        step();
        in_sel = 2'd1;
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({out_valid, out_sel_err, out_data, in_ready} !== 35'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %h expected 0", {out_valid, out_sel_err, out_data, in_ready});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        #1;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        out_ready = 1'b1;
        step();
        tests_run++;
        if ({out_valid, out_sel_err, out_data} !== {2'b10, 32'hBBBB_BBBB}) begin
            tests_failed++;
            $display("FAIL post_reset_push: got %h expected %h", {out_valid, out_sel_err, out_data}, {2'b10, 32'hBBBB_BBBB});
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 1000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_sel    = SEL_W'($urandom_range(0, 3));
            step();
            tests_run++;
            if ({out_valid, out_sel_err, out_data} !== exp_head() || in_ready !== (sb_q.size() < 2)) begin
                tests_failed++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_c%0d: got %h/%b expected %h/%b", c, {out_valid, out_sel_err, out_data}, in_ready, exp_head(), sb_q.size() < 2);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        tests_run++;
        if (out_valid !== 1'b0 || sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL random_drain: got %b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_full();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
